uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rr_pick.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 148 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and
// default sizing constants.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START     = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } uart_state_t;

   localparam int UART_NUM_REQ = 4;
   localparam int UART_BUSY_TO = 16;
   localparam int UART_IDX_W   = 3;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: lowest set request at or above rr_ptr,
// wrapping from NUM_REQ-1 back to 0.
module uart_rr_pick
   import uart_pkg::*;
#(
   parameter int NUM_REQ = UART_NUM_REQ
) (
   input  logic [NUM_REQ-1:0]    req,
   input  logic [UART_IDX_W-1:0] rr_ptr,
   output logic                  valid,
   output logic [UART_IDX_W-1:0] winner
);

   localparam int SUM_W = UART_IDX_W + 1;
   localparam logic [SUM_W-1:0] N_SUM = SUM_W'(NUM_REQ);

   logic [NUM_REQ-1:0]    rot;
   logic [UART_IDX_W-1:0] off;
   logic [SUM_W-1:0]      sum;

   always_comb begin
      // Rotate so that rr_ptr lands on bit 0, then take the lowest set bit.
      rot   = NUM_REQ'({req, req} >> rr_ptr);
      valid = |rot;
      off   = '0;
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
         if (rot[j]) off = UART_IDX_W'(j);
      end
      sum = {1'b0, rr_ptr} + {1'b0, off};
      if (sum >= N_SUM) sum = sum - N_SUM;
      winner = sum[UART_IDX_W-1:0];
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates NUM_REQ byte requesters onto one UART transmitter (round-robin).
// Define UART_ARB_LOCK_EN to let the current owner keep the grant via req_lock.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ = UART_NUM_REQ,
   parameter int BUSY_TO = UART_BUSY_TO
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_lock,
   output logic [NUM_REQ-1:0]   ack,
   output logic                 tx_start,
   output logic [7:0]           tx_data,
   input  logic                 tx_busy,
   output logic [2:0]           owner,
   output logic                 err_to
);

   localparam int CNT_W = $clog2(BUSY_TO + 1);
   localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(BUSY_TO - 1);
   localparam logic [UART_IDX_W-1:0] IDX_LAST = UART_IDX_W'(NUM_REQ - 1);
   localparam logic [UART_IDX_W-1:0] IDX_ONE  = UART_IDX_W'(1);

   uart_state_t           state_q, state_d;
   logic [UART_IDX_W-1:0] rr_ptr_q;
   logic [UART_IDX_W-1:0] owner_q;
   logic [7:0]            tx_data_q;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   logic                  pick_valid;
   logic [UART_IDX_W-1:0] pick_winner;
   logic                  lock_hit;
   logic                  grant_valid;
   logic                  grant;
   logic [UART_IDX_W-1:0] grant_idx;
   logic [UART_IDX_W-1:0] rr_next;
   logic [7:0]            grant_data;

   uart_rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_pick (
      .req    (req),
      .rr_ptr (rr_ptr_q),
      .valid  (pick_valid),
      .winner (pick_winner)
   );

`ifdef UART_ARB_LOCK_EN
   // owner only counts as a lock holder once something has been granted.
   logic owner_vld_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         owner_vld_q <= 1'b0;
      end else if (grant) begin
         owner_vld_q <= 1'b1;
      end
   end

   always_comb begin
      lock_hit = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (owner_q == UART_IDX_W'(i)) lock_hit = owner_vld_q & req[i] & req_lock[i];
      end
   end
`else
   logic unused_req_lock;
   assign unused_req_lock = ^req_lock;
   assign lock_hit        = 1'b0;
`endif

   always_comb begin
      grant_valid = lock_hit | pick_valid;
      grant_idx   = lock_hit ? owner_q : pick_winner;
      rr_next     = (pick_winner == IDX_LAST) ? '0 : pick_winner + IDX_ONE;
      grant_data  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_idx == UART_IDX_W'(i)) grant_data = req_data[8*i +: 8];
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      grant   = 1'b0;
      err_to  = 1'b0;
      case (state_q)
         IDLE: begin
            if (!tx_busy && grant_valid) begin
               grant   = 1'b1;
               state_d = START;
            end
         end
         START: begin
            cnt_d   = '0;
            state_d = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            // cnt_q counts prior WAIT_BUSY cycles, so this fires on cycle BUSY_TO after START.
            if (tx_busy) begin
               state_d = WAIT_DONE;
            end else if (cnt_q >= CNT_LAST) begin
               err_to  = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         WAIT_DONE: begin
            if (!tx_busy) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         rr_ptr_q  <= '0;
         owner_q   <= '0;
         tx_data_q <= 8'h00;
         cnt_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (grant) begin
            tx_data_q <= grant_data;
            owner_q   <= grant_idx;
            if (!lock_hit) rr_ptr_q <= rr_next;
         end
      end
   end

   always_comb begin
      ack = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         ack[i] = (state_q == START) && (owner_q == UART_IDX_W'(i));
      end
   end

   assign tx_start = (state_q == START);
   assign tx_data  = tx_data_q;
   assign owner    = owner_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (default parameters).
module tb_uart_tx_arbiter;

   localparam int NUM_REQ = 4;
   localparam int BUSY_TO = 16;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [NUM_REQ-1:0]   req;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_lock;
   logic [NUM_REQ-1:0]   ack;
   logic                 tx_start;
   logic [7:0]           tx_data;
   logic                 tx_busy;
   logic [2:0]           owner;
   logic                 err_to;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .NUM_REQ (NUM_REQ),
      .BUSY_TO (BUSY_TO)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .req_data (req_data),
      .req_lock (req_lock),
      .ack      (ack),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .tx_busy  (tx_busy),
      .owner    (owner),
      .err_to   (err_to)
   );

   function automatic logic [7:0] data_of(input int idx);
      case (idx)
         0:       return 8'h11;
         1:       return 8'h5A;
         2:       return 8'hA5;
         default: return 8'h3C;
      endcase
   endfunction

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset    = 1'b0;
      req      = '0;
      req_lock = '0;
      tx_busy  = 1'b0;
      next_cyc();
      next_cyc();
      reset = 1'b1;
   endtask

   // Called at the negedge of a START cycle; plays the transmitter and returns in IDLE.
   task automatic finish_tx();
      next_cyc();
      req     = '0;
      tx_busy = 1'b1;
      next_cyc();
      tx_busy = 1'b0;
      next_cyc();
   endtask

   // Drives req=r from an IDLE cycle, waits (bounded) for tx_start, then plays the transmitter.
   task automatic xfer(input logic [3:0] r, output logic [3:0] g_ack, output logic [7:0] g_data,
                       output logic [2:0] g_owner, output int n_ack, output bit found);
      found   = 1'b0;
      n_ack   = 0;
      g_ack   = '0;
      g_data  = '0;
      g_owner = '0;
      req     = r;
      tx_busy = 1'b0;
      for (int k = 0; k < 4 && !found; k++) begin
         @(negedge clk);
         n_ack += $countones(ack);
         if (tx_start === 1'b1) begin
            found   = 1'b1;
            g_ack   = ack;
            g_data  = tx_data;
            g_owner = owner;
         end else begin
            next_cyc();
         end
      end
      if (found) begin
         next_cyc();
         tx_busy = 1'b1;
         @(negedge clk);
         n_ack += $countones(ack);
         next_cyc();
         @(negedge clk);
         n_ack += $countones(ack);
         next_cyc();
         tx_busy = 1'b0;
         @(negedge clk);
         n_ack += $countones(ack);
         next_cyc();
      end
   endtask

   task automatic test_reset();
      reset    = 1'b0;
      req      = '0;
      req_lock = '0;
      tx_busy  = 1'b0;
      req_data = 32'h3CA5_5A11;
      @(negedge clk);
      @(negedge clk);
      n_total++;
      if (tx_start !== 1'b0) $display("FAIL reset_tx_start: got %b want 0", tx_start);
      else n_pass++;
      n_total++;
      if (ack !== 4'b0000) $display("FAIL reset_ack: got %b want 0000", ack);
      else n_pass++;
      n_total++;
      if (tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h want 00", tx_data);
      else n_pass++;
      n_total++;
      if (owner !== 3'd0) $display("FAIL reset_owner: got %0d want 0", owner);
      else n_pass++;
      n_total++;
      if (err_to !== 1'b0) $display("FAIL reset_err_to: got %b want 0", err_to);
      else n_pass++;
      next_cyc();
      reset = 1'b1;
   endtask

   task automatic test_single();
      int bad;
      apply_reset();
      req = 4'b0100;
      @(negedge clk);
      n_total++;
      if (tx_start !== 1'b0) $display("FAIL single_idle_start: got %b want 0", tx_start);
      else n_pass++;
      next_cyc();
      @(negedge clk);
      n_total++;
      if (tx_start !== 1'b1 || ack !== 4'b0100)
         $display("FAIL single_start_ack: got start=%b ack=%b want start=1 ack=0100", tx_start, ack);
      else n_pass++;
      n_total++;
      if (tx_data !== 8'hA5 || owner !== 3'd2)
         $display("FAIL single_data_owner: got data=%h owner=%0d want data=a5 owner=2", tx_data, owner);
      else n_pass++;
      next_cyc();
      req = '0;
      @(negedge clk);
      next_cyc();
      tx_busy = 1'b1;
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (ack !== 4'b0000 || tx_start !== 1'b0 || tx_data !== 8'hA5) bad++;
         next_cyc();
      end
      tx_busy = 1'b0;
      @(negedge clk);
      if (ack !== 4'b0000 || tx_start !== 1'b0 || tx_data !== 8'hA5) bad++;
      n_total++;
      if (bad !== 0) $display("FAIL single_hold: got %0d bad cycles want 0", bad);
      else n_pass++;
      next_cyc();
      req = 4'b0001;
      @(negedge clk);
      next_cyc();
      @(negedge clk);
      n_total++;
      if (tx_start !== 1'b1 || ack !== 4'b0001)
         $display("FAIL single_back_idle: got start=%b ack=%b want start=1 ack=0001", tx_start, ack);
      else n_pass++;
      finish_tx();
   endtask

   task automatic test_round_robin();
      int         exp_rr[5] = '{0, 1, 2, 3, 0};
      logic [3:0] g_ack;
      logic [7:0] g_data;
      logic [2:0] g_own;
      logic [3:0] oh;
      int         n_ack;
      bit         found;
      apply_reset();
      for (int i = 0; i < 5; i++) begin
         xfer(4'b1111, g_ack, g_data, g_own, n_ack, found);
         oh = 4'b0001 << exp_rr[i];
         n_total++;
         if (!found || g_ack !== oh || g_own !== 3'(exp_rr[i]) || g_data !== data_of(exp_rr[i]))
            $display("FAIL rr_grant_%0d: got found=%0d ack=%b owner=%0d data=%h want ack=%b owner=%0d data=%h",
                     i, found, g_ack, g_own, g_data, oh, exp_rr[i], data_of(exp_rr[i]));
         else n_pass++;
         n_total++;
         if (n_ack !== 1) $display("FAIL rr_ack_count_%0d: got %0d want 1", i, n_ack);
         else n_pass++;
      end
      req = '0;
   endtask

   task automatic test_timeout();
      int first_err;
      int n_err;
      req = 4'b0001;
      @(negedge clk);
      next_cyc();
      @(negedge clk);
      n_total++;
      if (tx_start !== 1'b1) $display("FAIL to_start: got %b want 1", tx_start);
      else n_pass++;
      next_cyc();
      req       = '0;
      first_err = -1;
      n_err     = 0;
      for (int k = 1; k <= BUSY_TO; k++) begin
         @(negedge clk);
         if (err_to === 1'b1) begin
            n_err++;
            if (first_err < 0) first_err = k;
         end
         next_cyc();
      end
      req = 4'b1000;
      @(negedge clk);
      if (err_to === 1'b1) n_err++;
      n_total++;
      if (first_err !== BUSY_TO || n_err !== 1)
         $display("FAIL to_err_pulse: got first=%0d count=%0d want first=%0d count=1", first_err, n_err, BUSY_TO);
      else n_pass++;
      next_cyc();
      @(negedge clk);
      n_total++;
      if (tx_start !== 1'b1 || ack !== 4'b1000 || owner !== 3'd3)
         $display("FAIL to_next_grant: got start=%b ack=%b owner=%0d want start=1 ack=1000 owner=3",
                  tx_start, ack, owner);
      else n_pass++;
      finish_tx();
   endtask

   task automatic test_busy_idle();
      int seen;
      tx_busy = 1'b1;
      req     = 4'b0010;
      seen    = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (tx_start === 1'b1 || ack !== 4'b0000) seen++;
         next_cyc();
      end
      tx_busy = 1'b0;
      @(negedge clk);
      if (tx_start === 1'b1) seen++;
      n_total++;
      if (seen !== 0) $display("FAIL busy_idle_hold: got %0d grant cycles want 0", seen);
      else n_pass++;
      next_cyc();
      @(negedge clk);
      n_total++;
      if (tx_start !== 1'b1 || ack !== 4'b0010)
         $display("FAIL busy_idle_release: got start=%b ack=%b want start=1 ack=0010", tx_start, ack);
      else n_pass++;
      finish_tx();
   endtask

   task automatic test_ignore();
      int seen_start;
      int seen_ack3;
      req = 4'b0001;
      @(negedge clk);
      next_cyc();
      @(negedge clk);
      n_total++;
      if (tx_start !== 1'b1 || ack !== 4'b0001)
         $display("FAIL ign_first: got start=%b ack=%b want start=1 ack=0001", tx_start, ack);
      else n_pass++;
      next_cyc();
      req     = '0;
      tx_busy = 1'b1;
      next_cyc();
      req        = 4'b1000;
      seen_start = 0;
      seen_ack3  = 0;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         if (tx_start === 1'b1) seen_start++;
         if (ack[3] === 1'b1) seen_ack3++;
         next_cyc();
         if (k == 0) req = '0;
         if (k == 1) tx_busy = 1'b0;
      end
      n_total++;
      if (seen_start !== 0 || seen_ack3 !== 0)
         $display("FAIL ign_pulse: got starts=%0d ack3=%0d want 0 and 0", seen_start, seen_ack3);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      req = 4'b0100;
      @(negedge clk);
      next_cyc();
      @(negedge clk);
      next_cyc();
      req     = '0;
      tx_busy = 1'b1;
      next_cyc();
      #2;
      reset = 1'b0;
      #1;
      n_total++;
      if (tx_start !== 1'b0 || ack !== 4'b0000 || err_to !== 1'b0)
         $display("FAIL rstmid_ctrl: got start=%b ack=%b err=%b want 0 0000 0", tx_start, ack, err_to);
      else n_pass++;
      n_total++;
      if (tx_data !== 8'h00 || owner !== 3'd0)
         $display("FAIL rstmid_data: got data=%h owner=%0d want 00 0", tx_data, owner);
      else n_pass++;
      tx_busy = 1'b0;
      next_cyc();
      next_cyc();
      next_cyc();
      reset = 1'b1;
      @(negedge clk);
      n_total++;
      if (tx_start !== 1'b0 || ack !== 4'b0000)
         $display("FAIL rstmid_no_ack: got start=%b ack=%b want 0 0000", tx_start, ack);
      else n_pass++;
      next_cyc();
      req = 4'b0010;
      @(negedge clk);
      next_cyc();
      @(negedge clk);
      n_total++;
      if (tx_start !== 1'b1 || ack !== 4'b0010 || owner !== 3'd1)
         $display("FAIL rstmid_grant: got start=%b ack=%b owner=%0d want 1 0010 1", tx_start, ack, owner);
      else n_pass++;
      finish_tx();
   endtask

   task automatic test_lock();
`ifdef UART_ARB_LOCK_EN
      int exp_lk[4] = '{0, 0, 0, 1};
`else
      int exp_lk[4] = '{0, 1, 0, 1};
`endif
      logic [3:0] g_ack;
      logic [7:0] g_data;
      logic [2:0] g_own;
      int         n_ack;
      bit         found;
      apply_reset();
      req_lock = 4'b0001;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) req_lock = 4'b0000;
         xfer(4'b0011, g_ack, g_data, g_own, n_ack, found);
         n_total++;
         if (!found || g_own !== 3'(exp_lk[i]) || n_ack !== 1)
            $display("FAIL lock_grant_%0d: got found=%0d owner=%0d acks=%0d want owner=%0d acks=1",
                     i, found, g_own, n_ack, exp_lk[i]);
         else n_pass++;
      end
      req      = '0;
      req_lock = '0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_timeout();
      test_busy_idle();
      test_ignore();
      test_reset_mid();
      test_lock();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
